// File: rtl/lfsr_carry_pkg.sv
// Shared types and constants for the LFSR carry extender: snapshot FSM states
// and reset values.
package lfsr_carry_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

  localparam int   WIDTH_DEF      = 16;
  localparam logic TC_RST_BIT     = 1'b1;
  localparam logic PREV_CARRY_RST = 1'b1;

endpackage

// File: rtl/carry_edge_det.sv
// Rising-edge detector on the upstream LFSR carry; one pulse per low-to-high
// transition of carry_i.
module carry_edge_det
  import lfsr_carry_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic carry_i,
  output logic rise_o
);

  logic prev_q;

  // Reset to high so a carry already asserted at reset release is not an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= PREV_CARRY_RST;
    end else begin
      prev_q <= carry_i;
    end
  end

  assign rise_o = carry_i & ~prev_q;

endmodule

// File: rtl/lfsr_carry_extender.sv
// High-order counter extending an upstream 3-bit LFSR stage: counts carry
// edges, flags terminal count and overflow, and offers a handshaked snapshot.
module lfsr_carry_extender
  import lfsr_carry_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int WRAP_AT_TC = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Carry_In,
  input  logic             Run,
  input  logic             Clr,
  input  logic             TC_Load,
  input  logic [WIDTH-1:0] TC_Value,
  input  logic             Snap,
  input  logic             Snap_Ack,
  output logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] Snap_Data,
  output logic             Snap_Valid,
  output logic             Match,
  output logic             Ovf
);

  logic [WIDTH-1:0] count_q, count_d, count_inc, tc_q, snap_data_q;
  logic             ovf_q, ovf_d, match_q, match_d;
  logic             rise, inc, snap_valid_q;
  snap_state_e      state_q;

  function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] v);
    return v + 1'b1;
  endfunction

  carry_edge_det u_edge (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .carry_i(Carry_In),
    .rise_o (rise)
  );

  assign inc       = rise & Run;
  assign count_inc = incr(count_q);

  // Compare against the TC register as it stood before any coincident load.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    match_d = 1'b0;
    if (Clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      if ((WRAP_AT_TC != 0) && (count_q == tc_q)) begin
        count_d = '0;
        match_d = 1'b1;
      end else begin
        count_d = count_inc;
        if (count_q == {WIDTH{1'b1}}) ovf_d = 1'b1;
        if ((WRAP_AT_TC == 0) && (count_inc == tc_q)) match_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
      tc_q    <= {WIDTH{TC_RST_BIT}};
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
      if (TC_Load) tc_q <= TC_Value;
    end
  end

  // Snapshot captures the pre-increment count; re-snap only with an ack.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (Snap) begin
        state_q      <= HOLD;
        snap_data_q  <= count_q;
        snap_valid_q <= 1'b1;
      end
    end else begin
      if (Snap && Snap_Ack) begin
        snap_data_q <= count_q;
      end else if (Snap_Ack) begin
        state_q      <= IDLE;
        snap_valid_q <= 1'b0;
      end
    end
  end

  assign Count      = count_q;
  assign Ovf        = ovf_q;
  assign Match      = match_q;
  assign Snap_Data  = snap_data_q;
  assign Snap_Valid = snap_valid_q;

endmodule

// File: doc/lfsr_carry_extender.md
LFSR_CARRY_EXTENDER -- requirements
Module: lfsr_carry_extender

Interface
REQ-001 Parameter WIDTH, default 16: width of the high-order count and terminal-count registers.
REQ-002 Parameter WRAP_AT_TC, default 0: 1 = count modulo (TC+1); 0 = free-run modulo 2^WIDTH.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Carry_In  input  1  Next output of the upstream 3-bit LFSR counter stage.
REQ-006 Run  input  1  count enable; 1 = carry edges increment Count.
REQ-007 Clr  input  1  synchronous clear pulse.
REQ-008 TC_Load  input  1  load strobe for the terminal-count register.
REQ-009 TC_Value  input  WIDTH  terminal-count value loaded on TC_Load.
REQ-010 Snap  input  1  snapshot request.
REQ-011 Snap_Ack  input  1  consumer acknowledge of snapshot.
REQ-012 Count  output  WIDTH  live high-order count.
REQ-013 Snap_Data  output  WIDTH  captured Count.
REQ-014 Snap_Valid  output  1  Snap_Data valid, held until acknowledged.
REQ-015 Match  output  1  one-cycle terminal-count pulse.
REQ-016 Ovf  output  1  sticky overflow flag.

Function
REQ-017 Inc SHALL be Carry_In=1 AND registered previous Carry_In=0 AND Run=1; a level held high SHALL produce one increment only.
REQ-018 Previous-carry register SHALL update every cycle regardless of Run, Clr, TC_Load.
REQ-019 Count SHALL change at the same edge Inc is sampled: latency one cycle from Carry_In rise to visible Count.
REQ-020 Priority SHALL be Rst > Clr > Inc; Clr coincident with Inc gives Count=0, increment lost.
REQ-021 Clr SHALL zero Count and Ovf; it SHALL NOT alter TC, Snap_Data, Snap_Valid.
REQ-022 WRAP_AT_TC=0: Inc at Count=all-ones SHALL give Count=0 and set Ovf; Match SHALL pulse on the edge where Count becomes TC.
REQ-023 WRAP_AT_TC=1: Inc at Count==TC SHALL give Count=0 and pulse Match; Ovf not set; TC=0 SHALL pulse Match on every Inc.
REQ-024 WRAP_AT_TC=1 with Count>TC (after TC reload): count continues to all-ones, wraps to 0, sets Ovf.
REQ-025 TC_Load coincident with Inc: compare SHALL use old TC; new TC effective next cycle.
REQ-026 Snapshot FSM states IDLE, HOLD; IDLE+Snap -> HOLD, Snap_Data = Count value present in the Snap cycle (pre-increment), Snap_Valid=1 next cycle.
REQ-027 HOLD+Snap_Ack (no Snap) -> IDLE, Snap_Valid=0 next cycle; HOLD+Snap without Ack SHALL be ignored.
REQ-028 HOLD+Snap+Snap_Ack SHALL recapture Count and remain in HOLD with Snap_Valid=1.
REQ-029 Snap_Ack in IDLE SHALL be ignored.

Reset
REQ-030 Rst SHALL set Count=0, Snap_Data=0, Snap_Valid=0, Match=0, Ovf=0, TC=all-ones, FSM=IDLE.
REQ-031 Rst SHALL set previous-carry register to 1, so Carry_In high at reset release causes no increment.
REQ-032 Rst mid-HOLD SHALL drop Snap_Valid on the next edge; pending snapshot is discarded.

Structure
REQ-033 Package lfsr_carry_pkg SHALL hold the snapshot state enum (IDLE, HOLD), WIDTH default, TC reset constant.
REQ-034 One sub-module carry_edge_det SHALL implement the previous-carry register and rising-edge pulse.

Verification
REQ-035 Rst, Run=1, 5 single-cycle Carry_In pulses -> Count=5, Match=0, Ovf=0.
REQ-036 Carry_In held high 10 cycles, Run=1 -> Count increments once; Carry_In high through reset release -> Count stays 0.
REQ-037 WRAP_AT_TC=1, TC=3, 8 carry pulses -> Count 1,2,3,0,1,2,3,0; Match pulses twice, Ovf=0.
REQ-038 WIDTH=4, WRAP_AT_TC=0, 16 pulses -> Count=0, Ovf=1; Clr -> Ovf=0.
REQ-039 Count=7, Snap coincident with carry edge -> Snap_Data=7, Count=8; second Snap before Ack ignored; Ack -> Snap_Valid=0.
REQ-040 Clr coincident with carry edge -> Count=0; TC_Load=5 coincident with Inc at old TC -> old TC compare applied.
